rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
Upstream producer for the double-buffered display path. It accepts rectangle-fill commands through a valid/ready handshake and writes clipped pixels into the current back image buffer, one pixel per clock. It also owns the ping-pong buffer select: on a producer swap request, it flips back and front buffers at the next end-of-scan pulse from the display reader. The reader consumes front_sel and scans that buffer at 160x120, 3-bit colour, address = y*160 + x.

Parameters:
SCR_W, 160, frame width in pixels
SCR_H, 120, frame height in pixels
COL_W, 3, colour bits per pixel
ADDR_W, 15, image buffer address width (covers 19200 locations)

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  engine can accept a command this cycle
req_clear  in  1  full-frame fill; req_x/y/w/h ignored
req_x  in  8  left column
req_y  in  7  top row
req_w  in  8  width in pixels
req_h  in  7  height in pixels
req_colour  in  COL_W  fill colour
swap_req  in  1  one-cycle pulse: back buffer is complete
scan_done  in  1  one-cycle pulse from reader: front scan finished
wr_en  out  1  image buffer write strobe
wr_sel  out  1  buffer targeted by wr_en (equals back_sel)
wr_addr  out  ADDR_W  pixel address y*SCR_W + x
wr_data  out  COL_W  pixel colour
front_sel  out  1  buffer the reader must scan (equals ~back_sel)
busy  out  1  high in FILL or WAIT_SWAP
swap_pending  out  1  swap requested, not yet performed

Behaviour:
- Reset (async): state IDLE; wr_en=0, wr_addr=0, wr_data=0, back_sel=0, front_sel=1, swap_pending=0, busy=0, req_ready=0 while reset is asserted.
- States: IDLE, FILL, WAIT_SWAP.
- req_ready is 1 only when in IDLE and swap_pending=0. A command is accepted on req_valid & req_ready; all req_* fields are latched.
- req_clear=1 is treated as x=0, y=0, w=SCR_W, h=SCR_H.
- Clipping: x_end = min(x+w, SCR_W) and y_end = min(y+h, SCR_H). Compute sums at 9/8 bits so there is no wrap.
- Empty command (w=0, h=0, x>=SCR_W or y>=SCR_H): accepted, no writes, and the engine stays in IDLE.
- FILL order is row-major, one pixel per cycle. Outputs are registered. The first wr_en occurs in the cycle after acceptance, with wr_addr = y*SCR_W + x.
- Address is generated incrementally with no multiplier:
  - Within a row: addr+1.
  - At row end: row_base += SCR_W and addr = row_base + x.
- Last write is at (x_end-1, y_end-1). The engine returns to IDLE the next cycle with wr_en=0, so a w*h clipped fill takes exactly w*h wr_en cycles.
- wr_data holds latched colour during FILL; wr_sel=back_sel.
- swap_req in IDLE sets swap_pending and moves to WAIT_SWAP.
- swap_req in FILL sets swap_pending. The fill completes, then the engine enters WAIT_SWAP instead of IDLE.
- WAIT_SWAP:
  - On scan_done, toggle back_sel/front_sel, clear swap_pending, return to IDLE.
  - scan_done in the same cycle that swap_req arrives is ignored; the swap waits for the next scan_done.
- scan_done outside WAIT_SWAP has no effect. A repeated swap_req while pending is ignored (no double flip).
- Reset mid-FILL aborts immediately; remaining pixels are never written.

Decomposition:
- Shared package display_pkg: SCR_W, SCR_H, COL_W, ADDR_W, colour constants (BLACK=3'b000, GREEN=3'b010, WHITE=3'b111) and the state encoding. The reader uses the same package.
- One natural sub-module, rect_addr_gen: walks clipped bounds and emits addr/last, with start/advance inputs.
- FSM, handshake and buffer select stay in rect_fill_engine.

Test Plan:
- Reset then idle: deassert reset → req_ready=1, front_sel=1, wr_en=0; no writes over 100 cycles.
- Rect x=8,y=8,w=8,h=8,colour=GREEN → 64 wr_en cycles.
  - First wr_addr=1288, then 1289…1295, then 1448.
  - Last addr=2415, wr_data=3'b010, wr_sel=0, req_ready low throughout.
- Clip x=156,y=118,w=10,h=5 → 8 writes: addrs 19036..19039 and 19196..19199.
- Empty commands w=0, then x=200 → no wr_en; req_ready is 1 again within 1 cycle.
- Swap during fill: 16x16 fill, swap_req at pixel 5.
  - All 256 pixels written; the engine then holds req_ready=0.
  - scan_done pulse → back_sel=1, front_sel=0, swap_pending=0. The next command writes with wr_sel=1.
- req_clear with WHITE → 19200 writes at addr 0..19199. Assert reset at pixel 1000 → wr_en=0 immediately; after release, state is IDLE and back_sel=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants, state encoding and rectangle clip helpers.
// Used by the fill engine and the display reader.
package display_pkg;

  localparam int SCR_W  = 160;
  localparam int SCR_H  = 120;
  localparam int COL_W  = 3;
  localparam int ADDR_W = 15;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] GREEN = 3'b010;
  localparam logic [COL_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] x_end;
    logic [6:0] y0;
    logic [6:0] y_end;
  } rect_bounds_t;

  // y*SCR_W as shift-add (160 = 128 + 32)
  function automatic logic [ADDR_W-1:0] row_base(
    input logic [6:0] y
  );
    logic [ADDR_W-1:0] yy;
    yy = {8'b0, y};
    return (yy << 7) + (yy << 5);
  endfunction

  function automatic rect_bounds_t clip_rect(
    input logic       clear,
    input logic [7:0] x,
    input logic [7:0] w,
    input logic [6:0] y,
    input logic [6:0] h
  );
    rect_bounds_t b;
    logic [8:0]   xs;
    logic [7:0]   ys;
    xs = {1'b0, x} + {1'b0, w};
    ys = {1'b0, y} + {1'b0, h};
    if (clear) begin
      b.x0    = '0;
      b.y0    = '0;
      b.x_end = 8'(SCR_W);
      b.y_end = 7'(SCR_H);
    end else begin
      b.x0    = x;
      b.y0    = y;
      b.x_end = (xs > 9'(SCR_W)) ? 8'(SCR_W) : xs[7:0];
      b.y_end = (ys > 8'(SCR_H)) ? 7'(SCR_H) : ys[6:0];
    end
    return b;
  endfunction

  function automatic logic rect_empty(
    input logic       clear,
    input logic [7:0] x,
    input logic [7:0] w,
    input logic [6:0] y,
    input logic [6:0] h
  );
    return !clear && ((w == 8'd0) || (h == 7'd0) ||
                      (x >= 8'(SCR_W)) || (y >= 7'(SCR_H)));
  endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// Row-major walker over a clipped rectangle.
// Addresses are built incrementally: +1 per pixel, +SCR_W per row.
module rect_addr_gen
  import display_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  rect_bounds_t      bounds,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [7:0]        x0_q;
  logic [7:0]        x_end_q;
  logic [6:0]        y_end_q;
  logic [7:0]        cur_x;
  logic [6:0]        cur_y;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] next_row;
  logic [ADDR_W-1:0] start_row;
  logic              row_end;

  assign next_row  = row_q + ADDR_W'(SCR_W);
  assign start_row = row_base(bounds.y0);
  assign row_end   = (cur_x + 8'd1) == x_end_q;
  assign last      = row_end && ((cur_y + 7'd1) == y_end_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      row_q   <= '0;
      addr    <= '0;
    end else if (start) begin
      x0_q    <= bounds.x0;
      x_end_q <= bounds.x_end;
      y_end_q <= bounds.y_end;
      cur_x   <= bounds.x0;
      cur_y   <= bounds.y0;
      row_q   <= start_row;
      addr    <= start_row + {7'b0, bounds.x0};
    end else if (advance && !last) begin
      if (row_end) begin
        cur_x <= x0_q;
        cur_y <= cur_y + 7'd1;
        row_q <= next_row;
        addr  <= next_row + {7'b0, x0_q};
      end else begin
        cur_x <= cur_x + 8'd1;
        addr  <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill into the back image buffer, one pixel per clock,
// plus ping-pong buffer select flipped on end-of-scan after a swap.
module rect_fill_engine
  import display_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_clear,
  input  logic [7:0]        req_x,
  input  logic [6:0]        req_y,
  input  logic [7:0]        req_w,
  input  logic [6:0]        req_h,
  input  logic [COL_W-1:0]  req_colour,
  input  logic              swap_req,
  input  logic              scan_done,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COL_W-1:0]  wr_data,
  output logic              front_sel,
  output logic              busy,
  output logic              swap_pending
);

  fill_state_t      state_q, state_d;
  logic             back_sel_q;
  logic             pend_q, pend_d;
  logic [COL_W-1:0] colour_q;
  rect_bounds_t     bounds;
  logic             empty;
  logic             accept;
  logic             start;
  logic             last;
  logic             flip;

  assign bounds = clip_rect(req_clear, req_x, req_w, req_y, req_h);
  assign empty  = rect_empty(req_clear, req_x, req_w, req_y, req_h);

  assign req_ready = (state_q == ST_IDLE) && !pend_q && !reset;
  assign accept    = req_valid && req_ready;
  assign start     = accept && !empty;
  assign flip      = (state_q == ST_WAIT_SWAP) && scan_done;

  rect_addr_gen u_addr (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .advance (state_q == ST_FILL),
    .bounds  (bounds),
    .addr    (wr_addr),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start)         state_d = ST_FILL;
        else if (swap_req) state_d = ST_WAIT_SWAP;
      end
      ST_FILL: begin
        if (last)
          state_d = (pend_q || swap_req) ? ST_WAIT_SWAP : ST_IDLE;
      end
      ST_WAIT_SWAP: begin
        if (scan_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // scan_done only counts once the swap is already pending in WAIT_SWAP
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_WAIT_SWAP) begin
      if (scan_done) pend_d = 1'b0;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      back_sel_q <= 1'b0;
      pend_q     <= 1'b0;
      colour_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (flip)   back_sel_q <= ~back_sel_q;
      if (accept) colour_q   <= req_colour;
    end
  end

  assign wr_en        = (state_q == ST_FILL);
  assign wr_sel       = back_sel_q;
  assign wr_data      = colour_q;
  assign front_sel    = ~back_sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign swap_pending = pend_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: commands push expected
// writes into a queue, a negedge monitor pops and compares.
module tb_rect_fill_engine;
  import display_pkg::*;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_clear;
  logic [7:0]        req_x;
  logic [6:0]        req_y;
  logic [7:0]        req_w;
  logic [6:0]        req_h;
  logic [COL_W-1:0]  req_colour;
  logic              swap_req;
  logic              scan_done;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [COL_W-1:0]  wr_data;
  logic              front_sel;
  logic              busy;
  logic              swap_pending;

  rect_fill_engine dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_clear    (req_clear),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_w        (req_w),
    .req_h        (req_h),
    .req_colour   (req_colour),
    .swap_req     (swap_req),
    .scan_done    (scan_done),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .front_sel    (front_sel),
    .busy         (busy),
    .swap_pending (swap_pending)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    int sel;
  } wr_t;

  wr_t exp_q[$];
  int  vec = 0;
  int  errs = 0;
  int  wr_cnt = 0;
  int  model_back = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vec++;
    errs++;
    $display("FAIL %s: bound expired", name);
  endtask

  // reference: plain loops over the clipped rectangle
  task automatic model_rect(input int x, input int y, input int w,
                            input int h, input bit clr, input int col);
    int xe, ye;
    if (clr) begin
      x = 0; y = 0; w = SCR_W; h = SCR_H;
    end
    xe = (x + w > SCR_W) ? SCR_W : x + w;
    ye = (y + h > SCR_H) ? SCR_H : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++) begin
        wr_t e;
        e.addr = yy * SCR_W + xx;
        e.data = col;
        e.sel  = model_back;
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clock) begin
    if (!reset && wr_en) begin
      wr_cnt++;
      chk("ready_low_in_fill", {31'b0, req_ready}, 0);
      if (exp_q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_write: addr %0d, none expected",
                 wr_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {17'b0, wr_addr}, e.addr);
        chk("wr_data", {29'b0, wr_data}, e.data);
        chk("wr_sel", {31'b0, wr_sel}, e.sel);
      end
    end
  end

  task automatic send(input int x, input int y, input int w,
                      input int h, input bit clr, input int col);
    int t;
    t = 0;
    @(negedge clock);
    while (!req_ready && t < 40000) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) begin
      fail_now("ready_timeout");
      return;
    end
    req_valid  = 1'b1;
    req_clear  = clr;
    req_x      = x[7:0];
    req_y      = y[6:0];
    req_w      = w[7:0];
    req_h      = h[6:0];
    req_colour = col[2:0];
    @(posedge clock);
    model_rect(x[7:0], y[6:0], w[7:0], h[6:0], clr, col);
    #1;
    req_valid = 1'b0;
    req_clear = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30000) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(negedge clock);
    chk("wr_en_after_fill", {31'b0, wr_en}, 0);
  endtask

  task automatic pulse_swap(input bit sw, input bit sd);
    @(negedge clock);
    swap_req  = sw;
    scan_done = sd;
    @(negedge clock);
    swap_req  = 1'b0;
    scan_done = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int t;
    t = 0;
    while (wr_cnt < target && t < 30000) begin
      @(posedge clock);
      t++;
    end
    if (wr_cnt < target) fail_now("write_wait");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_clear  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_colour = '0;
    swap_req   = 1'b0;
    scan_done  = 1'b0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_front", {31'b0, front_sel}, 1);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_addr", {17'b0, wr_addr}, 0);
    chk("rst_data", {29'b0, wr_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_pend", {31'b0, swap_pending}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    chk("idle_ready", {31'b0, req_ready}, 1);
    chk("idle_front", {31'b0, front_sel}, 1);

    base = wr_cnt;
    send(8, 8, 8, 8, 1'b0, GREEN);
    drain();
    chk("rect8_count", wr_cnt - base, 64);

    base = wr_cnt;
    send(156, 118, 10, 5, 1'b0, WHITE);
    drain();
    chk("clip_count", wr_cnt - base, 8);

    base = wr_cnt;
    send(10, 10, 0, 5, 1'b0, GREEN);
    @(negedge clock);
    chk("empty_w_ready", {31'b0, req_ready}, 1);
    send(200, 10, 5, 5, 1'b0, GREEN);
    @(negedge clock);
    chk("empty_x_ready", {31'b0, req_ready}, 1);
    repeat (5) @(negedge clock);
    chk("empty_count", wr_cnt - base, 0);

    for (int i = 0; i < 20; i++) begin
      send($urandom_range(0, 170), $urandom_range(0, 125),
           $urandom_range(0, 40), $urandom_range(0, 24),
           1'b0, $urandom_range(0, 7));
    end
    drain();

    base = wr_cnt;
    send(20, 30, 16, 16, 1'b0, BLACK);
    wait_writes(base + 5);
    pulse_swap(1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clock);
    chk("swap_fill_count", wr_cnt - base, 256);
    chk("wait_ready", {31'b0, req_ready}, 0);
    chk("wait_busy", {31'b0, busy}, 1);
    chk("wait_pend", {31'b0, swap_pending}, 1);
    chk("wait_front", {31'b0, front_sel}, 1);
    pulse_swap(1'b0, 1'b1);
    model_back = 1;
    chk("swap_front", {31'b0, front_sel}, 0);
    chk("swap_pend_clr", {31'b0, swap_pending}, 0);
    chk("swap_ready", {31'b0, req_ready}, 1);
    send(0, 0, 4, 2, 1'b0, GREEN);
    drain();

    pulse_swap(1'b0, 1'b1);
    chk("idle_scan_front", {31'b0, front_sel}, 0);
    pulse_swap(1'b1, 1'b1);
    chk("same_cyc_pend", {31'b0, swap_pending}, 1);
    chk("same_cyc_front", {31'b0, front_sel}, 0);
    pulse_swap(1'b0, 1'b1);
    model_back = 0;
    chk("flip2_front", {31'b0, front_sel}, 1);
    pulse_swap(1'b1, 1'b0);
    pulse_swap(1'b1, 1'b0);
    pulse_swap(1'b0, 1'b1);
    model_back = 1;
    chk("dbl_req_front", {31'b0, front_sel}, 0);
    pulse_swap(1'b0, 1'b1);
    chk("no_double_flip", {31'b0, front_sel}, 0);
    send(100, 50, 3, 3, 1'b0, WHITE);
    drain();

    base = wr_cnt;
    send(33, 44, 9, 9, 1'b1, WHITE);
    wait_writes(base + 1000);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_wr_en", {31'b0, wr_en}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ready", {31'b0, req_ready}, 0);
    chk("abort_front", {31'b0, front_sel}, 1);
    chk("abort_pend_exp", exp_q.size() > 18000, 1);
    exp_q.delete();
    model_back = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    chk("post_rst_ready", {31'b0, req_ready}, 1);
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_front", {31'b0, front_sel}, 1);
    send(5, 115, 4, 10, 1'b0, GREEN);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
